// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter slice.
package divider_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} div_arb_state_t;

  localparam int unsigned DIV_ARB_WIDTH = 32;

endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_grant,
  output logic          o_any
);

  always_comb begin : pick
    logic [PW:0] w_idx;
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // One extra bit keeps ptr+k from overflowing before the wrap subtraction.
      w_idx = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      if (!o_any && i_req[w_idx[PW-1:0]]) begin
        o_any   = 1'b1;
        o_grant = w_idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one sequential divider between N_REQ requesters, round-robin, one op in flight.
// Optional watchdog on the divider response: define DIV_ARB_TIMEOUT_EN.
module divider_arbiter
  import divider_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = DIV_ARB_WIDTH,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_dividend,
  input  logic [N_REQ*WIDTH-1:0] req_divisor,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_quotient,
  output logic [WIDTH-1:0]       resp_remainder,
  output logic                   resp_err,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  output logic                   div_in_valid,
  input  logic                   div_out_valid,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic [WIDTH-1:0]       div_remainder
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || MAX_WAIT < 1) begin : g_param_check
    $error("divider_arbiter: N_REQ must be >= 2 and MAX_WAIT >= 1");
  end

  div_arb_state_t   r_state, w_next;
  logic [N_REQ-1:0] r_pending;
  logic [WIDTH-1:0] r_slot_dvd [N_REQ];
  logic [WIDTH-1:0] r_slot_dvs [N_REQ];
  logic [PW-1:0]    r_rr_ptr, r_grant;
  logic [WIDTH-1:0] r_div_dividend, r_div_divisor;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_err;
  logic [PW-1:0]    w_grant;
  logic             w_any, w_take, w_zero, w_timeout;

  rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .i_req   (r_pending),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign w_take = (r_state == IDLE) && w_any;
  assign w_zero = (r_slot_dvs[w_grant] == '0);

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst || r_state != WAIT) r_wait_cnt <= '0;
    else                         r_wait_cnt <= r_wait_cnt + CW'(1);
  end

  assign w_timeout = (r_state == WAIT) && !div_out_valid && (r_wait_cnt == CW'(MAX_WAIT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    div_in_valid = 1'b0;
    resp_valid   = '0;
    resp_err     = 1'b0;
    unique case (r_state)
      IDLE:  if (w_any) w_next = w_zero ? RESP : ISSUE;
      ISSUE: begin
        div_in_valid = 1'b1;
        w_next       = WAIT;
      end
      WAIT:  if (div_out_valid || w_timeout) w_next = RESP;
      RESP: begin
        resp_valid = N_REQ'(1) << r_grant;
        resp_err   = r_err;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand slots carry no reset: they are only read while the matching pending bit is set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) begin
        r_slot_dvd[i] <= req_dividend[i*WIDTH +: WIDTH];
        r_slot_dvs[i] <= req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending      <= '0;
      r_rr_ptr       <= '0;
      r_grant        <= '0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_quot         <= '0;
      r_rem          <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_take) begin
        r_pending[w_grant] <= 1'b0;
        r_grant            <= w_grant;
        if (w_zero) begin
          r_quot <= '1;
          r_rem  <= r_slot_dvd[w_grant];
          r_err  <= 1'b1;
        end else begin
          r_div_dividend <= r_slot_dvd[w_grant];
          r_div_divisor  <= r_slot_dvs[w_grant];
          r_err          <= 1'b0;
        end
      end
      // A new request overrides the grant clear so a same-cycle re-request stays queued.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_valid[i]) r_pending[i] <= 1'b1;
      end
      if (r_state == WAIT && div_out_valid) begin
        r_quot <= div_quotient;
        r_rem  <= div_remainder;
      end else if (w_timeout) begin
        r_quot <= '0;
        r_rem  <= '0;
        r_err  <= 1'b1;
      end
      if (r_state == RESP) r_rr_ptr <= (r_grant == PW'(N_REQ - 1)) ? '0 : r_grant + PW'(1);
    end
  end

  assign div_dividend   = r_div_dividend;
  assign div_divisor    = r_div_divisor;
  assign resp_quotient  = r_quot;
  assign resp_remainder = r_rem;

endmodule
